// File: rtl/pipe_pkg.sv
// Shared definitions for elastic pipeline-stage buffers: default widths, NOP
// encoding and the two-bit occupancy state.
package pipe_pkg;

  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned PC_W_DEF    = 32;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  // Encoding is {skid_valid, main_valid}, so the state is read straight off the valid flops
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b01,
    ST_TWO   = 2'b11
  } occ_e;

endpackage

// File: rtl/pipe_skid_entry.sv
// One payload + valid register with load, hold and clear controls.
// Clear wins over load; a cleared entry holds CLR_VAL as its payload.
module pipe_skid_entry #(
  parameter int unsigned     W       = 64,
  parameter logic [W-1:0]    CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out,
  output logic         valid_out
);

  logic [W-1:0] data_d, data_q;
  logic         valid_d, valid_q;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear) begin
      data_d  = CLR_VAL;
      valid_d = 1'b0;
    end else if (load) begin
      data_d  = data_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      data_q  <= CLR_VAL;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_out  = data_q;
  assign valid_out = valid_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic pipeline-stage register: valid/ready handshake, two-entry skid buffer, flush.
// Define PIPE_BUBBLE_CNT_EN to add the saturating bubble_cnt output.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int unsigned INSTR_W   = INSTR_W_DEF,
  parameter int unsigned PC_W      = PC_W_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out
`ifdef PIPE_BUBBLE_CNT_EN
  ,
  output logic [31:0]        bubble_cnt
`endif
);

  localparam int unsigned PAYLOAD_W = INSTR_W + PC_W;
  localparam logic [INSTR_W-1:0]   NOP_W    = INSTR_W'(NOP_INSTR);
  localparam logic [PAYLOAD_W-1:0] MAIN_CLR = {NOP_W, {PC_W{1'b0}}};

  logic                 main_valid, skid_valid;
  logic [PAYLOAD_W-1:0] main_data, skid_data, main_in;
  logic                 main_load, main_clear, main_from_skid;
  logic                 skid_load, skid_clear;
  logic                 accept, deliver;
  occ_e                 state_c;

  assign accept  = in_valid & in_ready;
  assign deliver = out_valid & out_ready;
  assign state_c = occ_e'({skid_valid, main_valid});

  // Occupancy transitions; flush overrides any handshake activity
  always_comb begin
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    case (state_c)
      ST_EMPTY: main_load = accept;
      ST_ONE: begin
        if (accept && deliver) main_load  = 1'b1;
        else if (accept)       skid_load  = 1'b1;
        else if (deliver)      main_clear = 1'b1;
      end
      ST_TWO: begin
        if (deliver) begin
          main_load      = 1'b1;
          main_from_skid = 1'b1;
          skid_clear     = 1'b1;
        end
      end
      default: begin
        main_clear = 1'b1;
        skid_clear = 1'b1;
      end
    endcase
    if (flush) begin
      main_load  = 1'b0;
      skid_load  = 1'b0;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end
  end

  assign main_in = main_from_skid ? skid_data : {instr_in, pc_in};

  pipe_skid_entry #(.W(PAYLOAD_W), .CLR_VAL(MAIN_CLR)) u_main (
    .clk       (clk),
    .clr       (clr),
    .load      (main_load),
    .clear     (main_clear),
    .data_in   (main_in),
    .data_out  (main_data),
    .valid_out (main_valid)
  );

  pipe_skid_entry #(.W(PAYLOAD_W), .CLR_VAL('0)) u_skid (
    .clk       (clk),
    .clr       (clr),
    .load      (skid_load),
    .clear     (skid_clear),
    .data_in   ({instr_in, pc_in}),
    .data_out  (skid_data),
    .valid_out (skid_valid)
  );

  // Main payload is forced to NOP/0 whenever it is invalid, so outputs come straight from flops
  assign {instr_out, pc_out} = main_data;
  assign out_valid = main_valid;
  assign in_ready  = ~skid_valid;

`ifdef PIPE_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt_d, bubble_cnt_q;

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!main_valid && (bubble_cnt_q != 32'hFFFF_FFFF)) bubble_cnt_d = bubble_cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (clr) bubble_cnt_q <= '0;
    else     bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed self-checking bench for pipe_stage_buf (bubble counter checks when
// PIPE_BUBBLE_CNT_EN is defined).
module tb_pipe_stage_buf;

  logic        clk = 1'b0;
  logic        clr, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr_in, instr_out, pc_in, pc_out;
`ifdef PIPE_BUBBLE_CNT_EN
  logic [31:0] bubble_cnt;
`endif
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_stage_buf dut (
    .clk       (clk),
    .clr       (clr),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr_in  (instr_in),
    .pc_in     (pc_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .instr_out (instr_out),
    .pc_out    (pc_out)
`ifdef PIPE_BUBBLE_CNT_EN
    ,
    .bubble_cnt(bubble_cnt)
`endif
  );

  typedef struct {
    logic        clr, flush, iv;
    logic [31:0] instr, pc;
    logic        ordy;
    logic        del;        // delivery expected in this cycle (pre-edge)
    logic [31:0] del_instr;
    logic        ov, ir;     // expected after the edge
    logic [31:0] x_instr, x_pc;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic c, input logic f, input logic iv,
                              input logic [31:0] ins, input logic [31:0] pc,
                              input logic ordy, input logic del, input logic [31:0] di,
                              input logic ov, input logic ir,
                              input logic [31:0] xi, input logic [31:0] xp);
    vec_t v;
    v.clr = c; v.flush = f; v.iv = iv; v.instr = ins; v.pc = pc; v.ordy = ordy;
    v.del = del; v.del_instr = di; v.ov = ov; v.ir = ir; v.x_instr = xi; v.x_pc = xp;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic c, input logic f, input logic iv,
                       input logic [31:0] ins, input logic [31:0] pc, input logic ordy);
    clr = c; flush = f; in_valid = iv; instr_in = ins; pc_in = pc; out_ready = ordy;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);

    // reset
    vecs[0]  = mk(1,0,0,32'h0,  32'h0,  0, 0,32'h0,  0,1,32'h13,32'h0);
    vecs[1]  = mk(1,0,0,32'h0,  32'h0,  0, 0,32'h0,  0,1,32'h13,32'h0);
    vecs[2]  = mk(0,0,0,32'h0,  32'h0,  0, 0,32'h0,  0,1,32'h13,32'h0);
    // backpressure into TWO, then drain
    vecs[3]  = mk(0,0,1,32'hB0, 32'h200,0, 0,32'h0,  1,1,32'hB0,32'h200);
    vecs[4]  = mk(0,0,1,32'hB1, 32'h204,0, 0,32'h0,  1,0,32'hB0,32'h200);
    vecs[5]  = mk(0,0,1,32'hB2, 32'h208,0, 0,32'h0,  1,0,32'hB0,32'h200);
    vecs[6]  = mk(0,0,1,32'hB2, 32'h208,1, 1,32'hB0, 1,1,32'hB1,32'h204);
    vecs[7]  = mk(0,0,0,32'h0,  32'h0,  1, 1,32'hB1, 0,1,32'h13,32'h0);
    // flush in TWO
    vecs[8]  = mk(0,0,1,32'hC0, 32'h300,0, 0,32'h0,  1,1,32'hC0,32'h300);
    vecs[9]  = mk(0,0,1,32'hC1, 32'h304,0, 0,32'h0,  1,0,32'hC0,32'h300);
    vecs[10] = mk(0,1,0,32'h0,  32'h0,  0, 0,32'h0,  0,1,32'h13,32'h0);
    vecs[11] = mk(0,0,0,32'h0,  32'h0,  1, 0,32'h0,  0,1,32'h13,32'h0);
    // flush with simultaneous accept and deliver
    vecs[12] = mk(0,0,1,32'hD0, 32'h400,0, 0,32'h0,  1,1,32'hD0,32'h400);
    vecs[13] = mk(0,1,1,32'hD1, 32'h404,1, 1,32'hD0, 0,1,32'h13,32'h0);
    vecs[14] = mk(0,0,0,32'h0,  32'h0,  1, 0,32'h0,  0,1,32'h13,32'h0);
    // clr mid-transfer in TWO
    vecs[15] = mk(0,0,1,32'hE0, 32'h500,0, 0,32'h0,  1,1,32'hE0,32'h500);
    vecs[16] = mk(0,0,1,32'hE1, 32'h504,0, 0,32'h0,  1,0,32'hE0,32'h500);
    vecs[17] = mk(1,0,1,32'hE2, 32'h508,1, 1,32'hE0, 0,1,32'h13,32'h0);
    vecs[18] = mk(0,0,0,32'h0,  32'h0,  0, 0,32'h0,  0,1,32'h13,32'h0);

    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].clr, vecs[i].flush, vecs[i].iv, vecs[i].instr, vecs[i].pc, vecs[i].ordy);
      chk($sformatf("v%0d_deliver", i), 64'(out_valid & out_ready), 64'(vecs[i].del));
      if (vecs[i].del) chk($sformatf("v%0d_del_instr", i), 64'(instr_out), 64'(vecs[i].del_instr));
      tick();
      chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].ov));
      chk($sformatf("v%0d_in_ready", i),  64'(in_ready),  64'(vecs[i].ir));
      chk($sformatf("v%0d_instr_out", i), 64'(instr_out), 64'(vecs[i].x_instr));
      chk($sformatf("v%0d_pc_out", i),    64'(pc_out),    64'(vecs[i].x_pc));
    end

    // streaming A0..A7 at full rate with out_ready held high
    for (int i = 0; i <= 8; i++) begin
      drive(1'b0, 1'b0, (i < 8), 32'hA0 + 32'(i), 32'h100 + 32'(4 * i), 1'b1);
      chk($sformatf("s%0d_in_ready", i), 64'(in_ready), 64'd1);
      tick();
      if (i < 8) begin
        chk($sformatf("s%0d_out_valid", i), 64'(out_valid), 64'd1);
        chk($sformatf("s%0d_instr", i), 64'(instr_out), 64'(32'hA0 + 32'(i)));
        chk($sformatf("s%0d_pc", i), 64'(pc_out), 64'(32'h100 + 32'(4 * i)));
      end else begin
        chk("s_end_out_valid", 64'(out_valid), 64'd0);
        chk("s_end_instr", 64'(instr_out), 64'h13);
      end
    end

`ifdef PIPE_BUBBLE_CNT_EN
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    tick();
    tick();
    chk("cnt_reset", 64'(bubble_cnt), 64'd0);
    clr = 1'b0;
    repeat (5) tick();
    chk("cnt_idle5", 64'(bubble_cnt), 64'd5);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("cnt_after_flush", 64'(bubble_cnt), 64'd6);
    in_valid = 1'b1; instr_in = 32'hF0;
    tick();
    in_valid = 1'b0;
    chk("cnt_valid_hold", 64'(bubble_cnt), 64'd7);
    tick();
    chk("cnt_no_inc_valid", 64'(bubble_cnt), 64'd7);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("cnt_clr", 64'(bubble_cnt), 64'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
